eth_sb_apb_master: RTL
======================

Name: eth_sb_apb_master

Overview:
- APB initiator for the Ethernet sideband bus. It is the requester end of the same APB link that the sideband slave FSM responds to.
- Accepts single read/write commands on a valid/ready request port and runs each one as an APB SETUP→ACCESS transfer.
- Returns read data and error status on a valid/ready response port.
- Sits between the sideband command sequencer and any APB completer.

Parameters:
- ADDR_WIDTH, 32, width of request address and PADDR.
- DATA_WIDTH, 32, width of write/read data. Must be 32; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort. Must be ≥2; used only with the optional feature.

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_req_valid  in  1  command valid
- o_req_ready  out  1  command accepted when valid&&ready
- i_req_write  in  1  1=write, 0=read
- i_req_addr  in  ADDR_WIDTH  target address
- i_req_wdata  in  DATA_WIDTH  write data
- i_req_pstrb  in  4  write byte strobes
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&&ready
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_slverr  out  1  completer error or timeout
- o_rsp_timeout  out  1  transfer aborted by timeout
- o_eth_sb_psel  out  1  APB PSEL
- o_eth_sb_penable  out  1  APB PENABLE
- o_eth_sb_pwrite  out  1  APB PWRITE
- o_eth_sb_paddr  out  ADDR_WIDTH  APB PADDR
- o_eth_sb_pwdata  out  DATA_WIDTH  APB PWDATA
- o_eth_sb_pstrb  out  4  APB PSTRB
- i_eth_sb_pready  in  1  APB PREADY
- i_eth_sb_prdata  in  DATA_WIDTH  APB PRDATA
- i_eth_sb_pslverr  in  1  APB PSLVERR
- o_busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock i_clk. Reset i_reset is synchronous and active-high.
- Registered outputs: all outputs except o_req_ready and o_busy come from flops. o_req_ready and o_busy are decoded from the state register.
- Reset values: state=IDLE. psel, penable, pwrite, paddr, pwdata, pstrb all 0. rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout all 0.
- Reset mid-transfer: any in-flight transfer is dropped. APB signals go low on the reset edge and no response is produced.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: latch addr, write, wdata and pstrb onto the APB outputs; assert psel=1, penable=0; go to SETUP.
  - pstrb is forced to 0 for reads. pwdata is forced to 0 for reads.
- SETUP: exactly one cycle. Next edge sets penable=1 → ACCESS. Address, control and data are held stable.
- ACCESS:
  - Hold all APB signals while i_eth_sb_pready=0.
  - On the edge where pready=1:
    - Drop psel and penable to 0.
    - Capture prdata into rsp_rdata for reads; rsp_rdata=0 for writes.
    - Capture pslverr into rsp_slverr.
    - Set rsp_valid=1 → RESP.
- RESP:
  - Hold rsp_* stable until i_rsp_ready=1.
  - On that edge clear rsp_valid → IDLE. No new request is accepted in the same cycle.
- Latency: request accepted at edge N gives psel at N, penable at N+1. With zero-wait pready, rsp_valid rises at N+2. Minimum 4 cycles per command when i_rsp_ready is held high.
- Ignored inputs: i_req_* are ignored outside IDLE. i_eth_sb_pready/prdata/pslverr are ignored outside ACCESS.
- APB compliance: psel never drops between SETUP and ACCESS. penable is never high without psel. No back-to-back transfers, so psel always returns low for at least one cycle (the RESP cycle) between transfers.
- i_rsp_ready already high when rsp_valid rises: response completes in one RESP cycle.

Optional Feature:
- Macro: ETH_SB_APB_MST_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES) is cleared on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0, the next edge:
    - aborts the transfer (psel=penable=0);
    - sets rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0;
    - goes to RESP.
  - pready=1 on the final count cycle wins: normal completion, no timeout.
- Undefined: no counter. ACCESS waits indefinitely and o_rsp_timeout is tied 0.

Test Plan:
- Zero-wait write: addr 0xAABBCCDC, wdata 0x12345678, pstrb 0xF, pready=1 in ACCESS → psel 2 cycles, penable 1 cycle, PWDATA=0x12345678, response rdata=0, slverr=0, 4 cycles total.
- Read with 3 wait states: addr 0x00000040, pready low for 3 ACCESS cycles, then prdata=0x87654321 → rsp_rdata=0x87654321. PADDR/PWRITE=0/PSTRB=0 stable for all 5 psel cycles.
- Error read: pslverr=1 with pready → rsp_slverr=1, timeout=0. Response held 3 cycles with rsp_ready=0, then accepted; req_ready stays 0 until IDLE.
- Reset mid-ACCESS: i_reset=1 for one cycle during a wait state → next edge psel=penable=rsp_valid=0, req_ready=1, no response ever issued.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready held 0 → abort after 8 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rdata=0. Repeat with pready=1 on the 8th cycle → normal completion, timeout=0.
- Back-to-back requests: i_req_valid held high with two queued commands (write 0x10, read 0x14) → second accepted only after first response handshake; psel low for ≥1 cycle between transfers.

Source files
------------

// File: rtl/eth_sb_apb_master_if.sv
// eth_sb_apb_master_if
// Purpose: bundles the command request port, the response port and the APB
//          requester signals of the Ethernet sideband APB initiator.
// Signals (directions as seen from the initiator, modport master):
//   i_req_valid/o_req_ready/i_req_write/i_req_addr/i_req_wdata/i_req_pstrb
//                        : command request handshake and payload
//   o_rsp_valid/i_rsp_ready/o_rsp_rdata/o_rsp_slverr/o_rsp_timeout
//                        : response handshake and payload
//   o_eth_sb_psel/penable/pwrite/paddr/pwdata/pstrb
//                        : APB request signals
//   i_eth_sb_pready/prdata/pslverr
//                        : APB completer signals
// Modport slave is the mirror image, used by whatever drives commands and
// models the completer.
interface eth_sb_apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_write;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_pstrb;

  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    o_rsp_slverr;
  logic                    o_rsp_timeout;

  logic                    o_eth_sb_psel;
  logic                    o_eth_sb_penable;
  logic                    o_eth_sb_pwrite;
  logic [ADDR_WIDTH-1:0]   o_eth_sb_paddr;
  logic [DATA_WIDTH-1:0]   o_eth_sb_pwdata;
  logic [DATA_WIDTH/8-1:0] o_eth_sb_pstrb;
  logic                    i_eth_sb_pready;
  logic [DATA_WIDTH-1:0]   i_eth_sb_prdata;
  logic                    i_eth_sb_pslverr;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_pstrb,
    input  i_rsp_ready,
    input  i_eth_sb_pready, i_eth_sb_prdata, i_eth_sb_pslverr,
    output o_req_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout,
    output o_eth_sb_psel, o_eth_sb_penable, o_eth_sb_pwrite,
    output o_eth_sb_paddr, o_eth_sb_pwdata, o_eth_sb_pstrb
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_pstrb,
    output i_rsp_ready,
    output i_eth_sb_pready, i_eth_sb_prdata, i_eth_sb_pslverr,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout,
    input  o_eth_sb_psel, o_eth_sb_penable, o_eth_sb_pwrite,
    input  o_eth_sb_paddr, o_eth_sb_pwdata, o_eth_sb_pstrb
  );
endinterface

// File: rtl/eth_sb_apb_master.sv
// eth_sb_apb_master
// Purpose: APB initiator for the Ethernet sideband bus. Takes one read/write
//          command at a time from the request port, runs it as an APB
//          SETUP->ACCESS transfer and returns read data / error status on
//          the response port.
// Ports:
//   i_clk    : clock, all logic on the rising edge
//   i_reset  : synchronous active-high reset, drops any in-flight transfer
//   bus      : eth_sb_apb_master_if.master (request, response, APB signals)
//   o_busy   : high whenever the FSM is not IDLE
// Optional feature: define ETH_SB_APB_MST_TIMEOUT_EN to abort an ACCESS
//   phase that waits TIMEOUT_CYCLES cycles without PREADY. Without it the
//   ACCESS phase waits indefinitely and o_rsp_timeout is tied low.
module eth_sb_apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  eth_sb_apb_master_if.master   bus,
  output logic                  o_busy
);

  // Reject configurations the datapath does not support.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : gBadCfg
    $error("eth_sb_apb_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_slverr_q;
  logic                    rsp_timeout_q;

`ifdef ETH_SB_APB_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
`endif

  // Single registered FSM: every APB and response output is a flop updated
  // here. Read transfers force PWDATA/PSTRB to zero so the completer never
  // sees stale write data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef ETH_SB_APB_MST_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_req_valid) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= bus.i_req_write;
            paddr_q   <= bus.i_req_addr;
            pwdata_q  <= bus.i_req_write ? bus.i_req_wdata : '0;
            pstrb_q   <= bus.i_req_write ? bus.i_req_pstrb : '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
`ifdef ETH_SB_APB_MST_TIMEOUT_EN
          cnt_q     <= '0;
`endif
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY on the final count cycle still completes normally.
          if (bus.i_eth_sb_pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.i_eth_sb_prdata;
            rsp_slverr_q  <= bus.i_eth_sb_pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
`ifdef ETH_SB_APB_MST_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready      = (state_q == IDLE);
  assign o_busy               = (state_q != IDLE);
  assign bus.o_eth_sb_psel    = psel_q;
  assign bus.o_eth_sb_penable = penable_q;
  assign bus.o_eth_sb_pwrite  = pwrite_q;
  assign bus.o_eth_sb_paddr   = paddr_q;
  assign bus.o_eth_sb_pwdata  = pwdata_q;
  assign bus.o_eth_sb_pstrb   = pstrb_q;
  assign bus.o_rsp_valid      = rsp_valid_q;
  assign bus.o_rsp_rdata      = rsp_rdata_q;
  assign bus.o_rsp_slverr     = rsp_slverr_q;
  assign bus.o_rsp_timeout    = rsp_timeout_q;

endmodule
